// File: rtl/smi_frame_arbiter_x2_pkg.sv
// Shared flit definitions for the SMI frame arbiter: end-of-frame encoding,
// port identifiers and arbiter state encoding.
package smiFlitPkg;

  localparam logic [7:0] EOFC_MID = 8'd0;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } portIdx_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arbState_e;

  // Any nonzero eofc closes a frame, including values above FlitWidth.
  function automatic logic isEof(input logic [7:0] eofc);
    return eofc != EOFC_MID;
  endfunction

endpackage

// File: rtl/smi_frame_arbiter_x2_if.sv
// SMI flit link: valid/eofc/data forward, stop as backpressure.
interface smi_frame_arbiter_x2_if
  import smiFlitPkg::*;
#(
  parameter int FlitWidth = 8
);
  logic                   valid;
  logic [7:0]             eofc;
  logic [FlitWidth*8-1:0] data;
  logic                   stop;

  modport master (output valid, output eofc, output data, input stop);
  modport slave  (input valid, input eofc, input data, output stop);
endinterface

// File: rtl/smi_frame_arbiter_x2_out_reg.sv
// Single-entry registered flit stage; loads whenever empty or draining,
// so a load and a drain can share one cycle.
module smi_flit_out_reg
  import smiFlitPkg::*;
#(
  parameter int Width = 72
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             loadValid,
  input  logic [Width-1:0] loadData,
  input  logic             stop,
  output logic             valid,
  output logic [Width-1:0] data,
  output logic             canLoad
);

  assign canLoad = !valid || !stop;

  always_ff @(posedge clk) begin
    if (srst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (canLoad) begin
      valid <= loadValid;
      if (loadValid) data <= loadData;
    end
  end

endmodule

// File: rtl/smi_frame_arbiter_x2.sv
// Two-input frame-level round-robin arbiter in front of an SMI frame buffer.
// A grant is held from a frame's first flit until its end-of-frame flit.
module smi_frame_arbiter_x2
  import smiFlitPkg::*;
#(
  parameter int FlitWidth  = 8,
  parameter int CountWidth = 16
) (
  input  logic                  clk,
  input  logic                  srst,
  smi_frame_arbiter_x2_if.slave  dataInA,
  smi_frame_arbiter_x2_if.slave  dataInB,
  smi_frame_arbiter_x2_if.master dataOut,
  output logic [CountWidth-1:0] frameCountA,
  output logic [CountWidth-1:0] frameCountB
);

  localparam int DataW = FlitWidth * 8;
  localparam int RegW  = DataW + 8;

  arbState_e       state;
  portIdx_e        lastGrant;
  logic            canLoad;
  logic            allowA, allowB;
  logic            accA, accB;
  logic            loadValid;
  logic [RegW-1:0] loadData;
  logic [RegW-1:0] regData;
  logic            regValid;

  // In IDLE a port is only blocked by a competing valid on the port that
  // has priority, so each stop never depends on its own port's valid.
  always_comb begin
    allowA = 1'b0;
    allowB = 1'b0;
    unique case (state)
      LOCK_A: allowA = 1'b1;
      LOCK_B: allowB = 1'b1;
      default: begin
        allowA = !(dataInB.valid && lastGrant == PORT_A);
        allowB = !(dataInA.valid && lastGrant == PORT_B);
      end
    endcase
  end

  assign dataInA.stop = !allowA || !canLoad;
  assign dataInB.stop = !allowB || !canLoad;
  assign accA         = dataInA.valid && !dataInA.stop;
  assign accB         = dataInB.valid && !dataInB.stop;
  assign loadValid    = accA || accB;
  assign loadData     = accA ? {dataInA.eofc, dataInA.data} : {dataInB.eofc, dataInB.data};

  smi_flit_out_reg #(.Width(RegW)) outReg (
    .clk      (clk),
    .srst     (srst),
    .loadValid(loadValid),
    .loadData (loadData),
    .stop     (dataOut.stop),
    .valid    (regValid),
    .data     (regData),
    .canLoad  (canLoad)
  );

  assign dataOut.valid = regValid;
  assign dataOut.eofc  = regData[RegW-1:DataW];
  assign dataOut.data  = regData[DataW-1:0];

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= IDLE;
      lastGrant   <= PORT_B;
      frameCountA <= '0;
      frameCountB <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accA) begin
            if (isEof(dataInA.eofc)) begin
              lastGrant   <= PORT_A;
              frameCountA <= frameCountA + 1'b1;
            end else begin
              state <= LOCK_A;
            end
          end else if (accB) begin
            if (isEof(dataInB.eofc)) begin
              lastGrant   <= PORT_B;
              frameCountB <= frameCountB + 1'b1;
            end else begin
              state <= LOCK_B;
            end
          end
        end
        LOCK_A: begin
          if (accA && isEof(dataInA.eofc)) begin
            state       <= IDLE;
            lastGrant   <= PORT_A;
            frameCountA <= frameCountA + 1'b1;
          end
        end
        LOCK_B: begin
          if (accB && isEof(dataInB.eofc)) begin
            state       <= IDLE;
            lastGrant   <= PORT_B;
            frameCountB <= frameCountB + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smi_frame_arbiter_x2.sv
// Self-checking bench for smi_frame_arbiter_x2: directed scenarios plus a
// randomized run scored against a frame-level reference model.
module tb_smi_frame_arbiter_x2;

  localparam int FW = 8;
  localparam int CW = 8;  // narrow counters so wrap-around is reachable quickly

  typedef struct {
    logic [7:0]  eofc;
    logic [63:0] data;
    int          gap;
  } flit_t;

  logic clk = 1'b0;
  logic srst;
  logic [CW-1:0] cntA, cntB;

  smi_frame_arbiter_x2_if #(.FlitWidth(FW)) inA ();
  smi_frame_arbiter_x2_if #(.FlitWidth(FW)) inB ();
  smi_frame_arbiter_x2_if #(.FlitWidth(FW)) outIf ();

  smi_frame_arbiter_x2 #(.FlitWidth(FW), .CountWidth(CW)) dut (
    .clk        (clk),
    .srst       (srst),
    .dataInA    (inA),
    .dataInB    (inB),
    .dataOut    (outIf),
    .frameCountA(cntA),
    .frameCountB(cntB)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;
  int stallAt = 0;
  int bStall  = 0;
  logic lockA, lockB;

  flit_t qA[$], qB[$], sentA[$], sentB[$], expQ[$];
  logic [71:0] gotQ[$];

  function automatic flit_t mk(input logic [7:0] tag, input int frame, input int idx,
                               input logic [7:0] eofc, input int gap);
    flit_t f;
    f.eofc = eofc;
    f.data = {tag, 8'(frame), 8'(idx), 8'h00, $urandom()};
    f.gap  = gap;
    return f;
  endfunction

  task automatic clear_model();
    qA.delete(); qB.delete(); sentA.delete(); sentB.delete();
    expQ.delete(); gotQ.delete();
    lockA = 1'b0; lockB = 1'b0;
  endtask

  task automatic idle_inputs();
    inA.valid = 1'b0; inA.eofc = 8'd0; inA.data = '0;
    inB.valid = 1'b0; inB.eofc = 8'd0; inB.data = '0;
    outIf.stop = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clear_model();
    srst = 1'b1;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
  endtask

  // Cycle engine: presents queued flits honouring stop, records accepted and
  // delivered flits, and checks per-cycle protocol rules along the way.
  task automatic run(input int maxCyc, input int stopMode, output int cycles);
    int n = 0;
    int gA, gB;
    logic vA, vB, aA, aB;
    logic hold = 1'b0, expPend = 1'b0;
    logic [71:0] prevOut = '0, expOut = '0;
    gA = (qA.size() > 0) ? qA[0].gap : 0;
    gB = (qB.size() > 0) ? qB[0].gap : 0;
    bStall = 0;
    while ((qA.size() > 0 || qB.size() > 0 || outIf.valid) && n < maxCyc) begin
      vA = (qA.size() > 0) && (gA == 0);
      vB = (qB.size() > 0) && (gB == 0);
      inA.valid = vA; inA.eofc = vA ? qA[0].eofc : 8'd0; inA.data = vA ? qA[0].data : '0;
      inB.valid = vB; inB.eofc = vB ? qB[0].eofc : 8'd0; inB.data = vB ? qB[0].data : '0;
      case (stopMode)
        0:       outIf.stop = 1'b0;
        1:       outIf.stop = ($urandom_range(0, 3) == 0);
        default: outIf.stop = (n >= stallAt && n < stallAt + 3);
      endcase
      #1;
      if (expPend) begin
        nChecks++;
        if (outIf.valid !== 1'b1 || {outIf.eofc, outIf.data} !== expOut)
          $display("FAIL latency: got valid=%b flit=%h, want valid=1 flit=%h",
                   outIf.valid, {outIf.eofc, outIf.data}, expOut);
        else nPass++;
      end
      if (hold) begin
        nChecks++;
        if (outIf.valid !== 1'b1 || {outIf.eofc, outIf.data} !== prevOut)
          $display("FAIL hold: got valid=%b flit=%h, want valid=1 flit=%h",
                   outIf.valid, {outIf.eofc, outIf.data}, prevOut);
        else nPass++;
      end
      if (outIf.valid && outIf.stop) begin
        nChecks++;
        if (inA.stop !== 1'b1 || inB.stop !== 1'b1)
          $display("FAIL full_stop: got stopA=%b stopB=%b, want 1 1", inA.stop, inB.stop);
        else nPass++;
      end
      if (lockA) begin
        nChecks++;
        if (inB.stop !== 1'b1) $display("FAIL lockA_blocksB: got stopB=%b, want 1", inB.stop);
        else nPass++;
      end
      if (lockB) begin
        nChecks++;
        if (inA.stop !== 1'b1) $display("FAIL lockB_blocksA: got stopA=%b, want 1", inA.stop);
        else nPass++;
      end
      aA = vA && !inA.stop;
      aB = vB && !inB.stop;
      if (vB && inB.stop) bStall++;
      expPend = aA || aB;
      if (aA) expOut = {qA[0].eofc, qA[0].data};
      else if (aB) expOut = {qB[0].eofc, qB[0].data};
      if (outIf.valid && !outIf.stop) gotQ.push_back({outIf.eofc, outIf.data});
      hold    = outIf.valid && outIf.stop;
      prevOut = {outIf.eofc, outIf.data};
      @(posedge clk);
      #1;
      if (aA) begin
        lockA = (qA[0].eofc == 8'd0);
        sentA.push_back(qA[0]);
        void'(qA.pop_front());
        gA = (qA.size() > 0) ? qA[0].gap : 0;
      end else if (gA > 0) gA--;
      if (aB) begin
        lockB = (qB[0].eofc == 8'd0);
        sentB.push_back(qB[0]);
        void'(qB.pop_front());
        gB = (qB.size() > 0) ? qB[0].gap : 0;
      end else if (gB > 0) gB--;
      n++;
    end
    nChecks++;
    if (n >= maxCyc) $display("FAIL timeout: ran %0d cycles, want fewer than %0d", n, maxCyc);
    else nPass++;
    idle_inputs();
    cycles = n;
  endtask

  // Output must be whole frames, each taken in order from one port's accepted stream.
  task automatic check_frames(input string name);
    int ia = 0, ib = 0, cur = 0;
    logic ok = 1'b1;
    for (int i = 0; i < gotQ.size(); i++) begin
      if (cur == 0) begin
        if (ia < sentA.size() && gotQ[i] === {sentA[ia].eofc, sentA[ia].data}) cur = 1;
        else if (ib < sentB.size() && gotQ[i] === {sentB[ib].eofc, sentB[ib].data}) cur = 2;
        else begin ok = 1'b0; break; end
      end
      if (cur == 1) begin
        if (ia >= sentA.size() || gotQ[i] !== {sentA[ia].eofc, sentA[ia].data}) begin ok = 1'b0; break; end
        ia++;
      end else begin
        if (ib >= sentB.size() || gotQ[i] !== {sentB[ib].eofc, sentB[ib].data}) begin ok = 1'b0; break; end
        ib++;
      end
      if (gotQ[i][71:64] != 8'd0) cur = 0;
    end
    nChecks++;
    if (!ok || ia != sentA.size() || ib != sentB.size() || cur != 0)
      $display("FAIL %s: matched A %0d/%0d B %0d/%0d of %0d outputs, want all whole frames",
               name, ia, sentA.size(), ib, sentB.size(), gotQ.size());
    else nPass++;
  endtask

  task automatic check_order(input string name);
    nChecks++;
    if (gotQ.size() != expQ.size()) begin
      $display("FAIL %s_len: got %0d flits, want %0d", name, gotQ.size(), expQ.size());
    end else begin
      int bad = -1;
      for (int i = 0; i < expQ.size(); i++)
        if (bad < 0 && gotQ[i] !== {expQ[i].eofc, expQ[i].data}) bad = i;
      if (bad >= 0)
        $display("FAIL %s: flit %0d got %h want %h", name, bad, gotQ[bad],
                 {expQ[bad].eofc, expQ[bad].data});
      else nPass++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    nChecks++; if (outIf.valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", outIf.valid); else nPass++;
    nChecks++; if (outIf.eofc !== 8'd0) $display("FAIL rst_eofc: got %h want 00", outIf.eofc); else nPass++;
    nChecks++; if (outIf.data !== 64'd0) $display("FAIL rst_data: got %h want 0", outIf.data); else nPass++;
    nChecks++; if (cntA !== '0 || cntB !== '0) $display("FAIL rst_counts: got %0d %0d want 0 0", cntA, cntB); else nPass++;
    nChecks++; if (inA.stop !== 1'b0 || inB.stop !== 1'b0)
      $display("FAIL rst_stops: got %b %b want 0 0", inA.stop, inB.stop); else nPass++;
  endtask

  task automatic test_alternate();
    int cyc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      qA.push_back(mk(8'hA0, i, 0, 8'd1, 0));
      qB.push_back(mk(8'hB0, i, 0, 8'd1, 0));
    end
    for (int i = 0; i < 4; i++) begin expQ.push_back(qA[i]); expQ.push_back(qB[i]); end
    run(50, 0, cyc);
    check_order("alternate");
    nChecks++; if (cyc != 9) $display("FAIL alt_throughput: got %0d cycles want 9", cyc); else nPass++;
    nChecks++; if (cntA !== CW'(4) || cntB !== CW'(4))
      $display("FAIL alt_counts: got %0d %0d want 4 4", cntA, cntB); else nPass++;
  endtask

  task automatic test_lock();
    int cyc;
    do_reset();
    qA.push_back(mk(8'hA0, 0, 0, 8'd0, 0));
    qA.push_back(mk(8'hA0, 0, 1, 8'd0, 0));
    qA.push_back(mk(8'hA0, 0, 2, 8'd0, 0));
    qA.push_back(mk(8'hA0, 0, 3, 8'd8, 0));
    qB.push_back(mk(8'hB0, 0, 0, 8'd1, 0));
    for (int i = 0; i < 4; i++) expQ.push_back(qA[i]);
    expQ.push_back(qB[0]);
    run(50, 0, cyc);
    check_order("lock");
    nChecks++; if (bStall != 4) $display("FAIL lock_bstall: got %0d cycles want 4", bStall); else nPass++;
    nChecks++; if (cntA !== CW'(1) || cntB !== CW'(1))
      $display("FAIL lock_counts: got %0d %0d want 1 1", cntA, cntB); else nPass++;
  endtask

  task automatic test_stall();
    int cyc;
    do_reset();
    for (int i = 0; i < 4; i++) qA.push_back(mk(8'hA0, 0, i, (i == 3) ? 8'd5 : 8'd0, 0));
    qB.push_back(mk(8'hB0, 0, 0, 8'd2, 0));
    for (int i = 0; i < 4; i++) expQ.push_back(qA[i]);
    expQ.push_back(qB[0]);
    stallAt = 2;
    run(50, 2, cyc);
    check_order("stall");
  endtask

  task automatic test_gaps();
    int cyc;
    do_reset();
    for (int i = 0; i < 4; i++) qA.push_back(mk(8'hA0, 0, i, (i == 3) ? 8'd3 : 8'd0, (i == 0) ? 0 : 2));
    qB.push_back(mk(8'hB0, 0, 0, 8'd4, 0));
    for (int i = 0; i < 4; i++) expQ.push_back(qA[i]);
    expQ.push_back(qB[0]);
    run(80, 0, cyc);
    check_order("gaps");
  endtask

  task automatic test_random();
    int cyc, len;
    logic [7:0] last;
    do_reset();
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        last = ($urandom_range(0, 7) == 0) ? 8'hC3 : 8'($urandom_range(1, 8));
        qA.push_back(mk(8'hA0, f, i, (i == len - 1) ? last : 8'd0, $urandom_range(0, 2)));
      end
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        last = ($urandom_range(0, 7) == 0) ? 8'hF0 : 8'($urandom_range(1, 8));
        qB.push_back(mk(8'hB0, f, i, (i == len - 1) ? last : 8'd0, $urandom_range(0, 2)));
      end
    end
    run(3000, 1, cyc);
    check_frames("random_frames");
    nChecks++; if (cntA !== CW'(30) || cntB !== CW'(30))
      $display("FAIL random_counts: got %0d %0d want 30 30", cntA, cntB); else nPass++;
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset();
    for (int i = 0; i < 255; i++) qA.push_back(mk(8'hA0, i, 0, 8'd1, 0));
    run(600, 0, cyc);
    nChecks++; if (cntA !== 8'hFF) $display("FAIL wrap_max: got %h want ff", cntA); else nPass++;
    qA.push_back(mk(8'hA0, 255, 0, 8'd1, 0));
    run(20, 0, cyc);
    nChecks++; if (cntA !== 8'h00) $display("FAIL wrap_zero: got %h want 00", cntA); else nPass++;
  endtask

  task automatic test_reset_midframe();
    int cyc;
    do_reset();
    qB.push_back(mk(8'hB0, 0, 0, 8'd1, 0));
    run(20, 0, cyc);
    nChecks++; if (cntB !== CW'(1)) $display("FAIL mid_precount: got %0d want 1", cntB); else nPass++;
    inB.valid = 1'b1; inB.eofc = 8'd0; inB.data = 64'hB1B1_0000_DEAD_BEEF;
    @(posedge clk); #1;
    idle_inputs();
    outIf.stop = 1'b1;
    #1;
    nChecks++; if (outIf.valid !== 1'b1 || inA.stop !== 1'b1)
      $display("FAIL mid_full: got valid=%b stopA=%b want 1 1", outIf.valid, inA.stop); else nPass++;
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    idle_inputs();
    clear_model();
    #1;
    nChecks++; if (outIf.valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", outIf.valid); else nPass++;
    nChecks++; if (cntA !== '0 || cntB !== '0) $display("FAIL mid_counts: got %0d %0d want 0 0", cntA, cntB); else nPass++;
    nChecks++; if (inA.stop !== 1'b0 || inB.stop !== 1'b0)
      $display("FAIL mid_stops: got %b %b want 0 0", inA.stop, inB.stop); else nPass++;
    @(posedge clk); #1;
    qA.push_back(mk(8'hA0, 0, 0, 8'd1, 0));
    qB.push_back(mk(8'hB0, 0, 0, 8'd1, 0));
    expQ.push_back(qA[0]);
    expQ.push_back(qB[0]);
    run(20, 0, cyc);
    check_order("mid_first_tie");
  endtask

  initial begin
    srst = 1'b1;
    idle_inputs();
    clear_model();
    test_reset();
    test_alternate();
    test_lock();
    test_stall();
    test_gaps();
    test_random();
    test_wrap();
    test_reset_midframe();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
